// File: rtl/mem_word_streamer_pkg.sv
// Shared defaults and types for the operand-ROM word streamer.
package mem_word_streamer_pkg;

    // Operand ROM geometry: 128 words of 32 bits, addressed by word.
    localparam int unsigned DEF_ADDR_WIDTH   = 7;
    localparam int unsigned DEF_DATA_WIDTH   = 32;
    localparam int unsigned DEF_NUM_WORDS    = 128;

    // ROM registers address and output; prefetch buffer must cover the
    // read pipeline plus one word in flight to the consumer.
    localparam int unsigned DEF_READ_LATENCY = 2;
    localparam int unsigned DEF_FIFO_DEPTH   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } stream_state_t;

endpackage

// File: rtl/mem_word_streamer_word_fifo.sv
// Synchronous prefetch FIFO; head entry is read straight from registered storage.
module word_fifo #(
    parameter  int unsigned WIDTH = 33,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH + 1),
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];

    // Storage, pointers and occupancy; push and pop together hold the count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_word_streamer.sv
// Streams one NUM_WORDS operand from a registered ROM through a prefetch FIFO.
module mem_word_streamer
    import mem_word_streamer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned NUM_WORDS    = DEF_NUM_WORDS,
    parameter int unsigned READ_LATENCY = DEF_READ_LATENCY,
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = $clog2(FIFO_DEPTH + READ_LATENCY + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

    stream_state_t          state;
    stream_state_t          state_next;
    logic [ADDR_WIDTH-1:0]  addr;
    logic                   accept;
    logic                   issue;
    logic                   issue_last;
    logic                   last_xfer;
    logic                   done_q;
    logic [READ_LATENCY-1:0] inflight_pipe;
    logic [READ_LATENCY-1:0] last_pipe;
    logic [SW-1:0]          inflight_cnt;
    logic [CW-1:0]          fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_WIDTH:0]    fifo_head;

    assign out_valid   = !fifo_empty;
    assign out_data    = fifo_head[DATA_WIDTH-1:0];
    assign out_last    = fifo_head[DATA_WIDTH] && !fifo_empty;
    assign last_xfer   = out_valid && out_ready && out_last;
    assign mem_address = addr;
    assign done        = done_q;
    assign busy        = (state != ST_IDLE) || done_q;

    // Count reads still travelling through the ROM pipeline.
    always_comb begin
        inflight_cnt = '0;
        for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + SW'(inflight_pipe[i]);
        end
    end

    // Next-state and read-issue decision; a read is only issued when the FIFO
    // is guaranteed to have room for it on arrival.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue      = 1'b0;
        issue_last = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (!fifo_full && (SW'(fifo_count) + inflight_cnt < SW'(FIFO_DEPTH))) begin
                    issue = 1'b1;
                    if (addr == LAST_ADDR) begin
                        issue_last = 1'b1;
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (last_xfer) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Saturating word address; restarts at zero on each accepted start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr <= '0;
        end else if (accept) begin
            addr <= '0;
        end else if (issue && (addr != LAST_ADDR)) begin
            addr <= addr + 1'b1;
        end
    end

    // Issue flags (and last-word tags) shifted alongside the ROM pipeline.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight_pipe <= '0;
            last_pipe     <= '0;
        end else begin
            inflight_pipe[0] <= issue;
            last_pipe[0]     <= issue_last;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                inflight_pipe[i] <= inflight_pipe[i-1];
                last_pipe[i]     <= last_pipe[i-1];
            end
        end
    end

    // One-cycle completion pulse after the last word leaves.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= last_xfer;
        end
    end

    word_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (inflight_pipe[READ_LATENCY-1]),
        .push_data ({last_pipe[READ_LATENCY-1], mem_q}),
        .pop       (out_ready),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_mem_word_streamer.sv
// Directed bench: scenario table for streaming patterns plus hand-written
// restart and reset sequences, checked against a bench-side ROM scoreboard.
module tb_mem_word_streamer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic [6:0]  mem_address;
    logic [31:0] mem_q;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [6:0]  rom_addr_q;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string name;
        int    mode;       // 0 always ready, 1 toggling, 2 stall 10 cycles
        int    exp_first;  // cycles from start edge to first out_valid
        int    exp_last;   // cycle of the last transfer, -1 if not fixed
    } vec_t;

    vec_t vecs[3];

    mem_word_streamer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .mem_address (mem_address),
        .mem_q       (mem_q),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    // Two-stage registered ROM holding word i = A5000000 + i.
    always_ff @(posedge clock) begin
        rom_addr_q <= mem_address;
        mem_q      <= 32'hA500_0000 + 32'(rom_addr_q);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic ready_for(input int mode, input int c, input int f);
        case (mode)
            1:       return (c % 2 == 0);
            2:       return !(f >= 0 && c >= f && c < f + 10);
            default: return 1'b1;
        endcase
    endfunction

    task automatic run_stream(input string name, input int mode, input int exp_first,
                              input int exp_last, input bit mid_start, input bit restart,
                              input bit skip_start);
        int idx = 0;
        int f = -1;
        int last_c = -1;
        int done_c = -1;
        int done_cnt = 0;
        bit timeout = 1'b1;
        if (!skip_start) begin
            @(negedge clock);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        check({name, "_busy_start"}, 64'(busy), 64'd1);
        for (int c = 0; c < 600; c++) begin
            if (out_valid && f < 0) f = c;
            out_ready = ready_for(mode, c, f);
            start = (mid_start && idx == 20) || (restart && done);
            if (mode == 2 && f >= 0 && c == f + 9) begin
                check({name, "_stall_addr"}, 64'(mem_address), 64'd4);
                check({name, "_stall_head"}, 64'(out_data), 64'hA500_0000);
            end
            if (done) begin
                done_cnt++;
                if (done_c < 0) done_c = c;
                check({name, "_busy_in_done"}, 64'(busy), 64'd1);
            end
            if (out_valid && out_ready) begin
                check({name, "_data"}, 64'(out_data), 64'(32'hA500_0000 + idx));
                check({name, "_last"}, 64'(out_last), 64'(idx == 127));
                if (idx == 127) last_c = c;
                idx++;
            end
            if (done_c >= 0 && (restart || c >= done_c + 2)) begin
                timeout = 1'b0;
                break;
            end
            @(negedge clock);
        end
        if (restart) begin
            @(negedge clock);
            start = 1'b0;
        end
        check({name, "_timeout"}, 64'(timeout), 64'd0);
        check({name, "_words"}, 64'(idx), 64'd128);
        check({name, "_first_valid"}, 64'(f), 64'(exp_first));
        if (exp_last >= 0) check({name, "_last_cycle"}, 64'(last_c), 64'(exp_last));
        check({name, "_done_cycle"}, 64'(done_c), 64'(last_c + 1));
        check({name, "_done_count"}, 64'(done_cnt), 64'd1);
        if (!restart) check({name, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int n;
        vecs[0] = '{name: "ready_high", mode: 0, exp_first: 3, exp_last: 130};
        vecs[1] = '{name: "ready_toggle", mode: 1, exp_first: 3, exp_last: -1};
        vecs[2] = '{name: "stall10", mode: 2, exp_first: 3, exp_last: 140};

        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_mem_address", 64'(mem_address), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            run_stream(vecs[i].name, vecs[i].mode, vecs[i].exp_first, vecs[i].exp_last, 1'b0, 1'b0, 1'b0);
        end

        // Start ignored at word 20, then accepted in the done cycle.
        run_stream("midstart", 0, 3, 130, 1'b1, 1'b1, 1'b0);
        run_stream("restarted", 0, 3, 130, 1'b0, 1'b0, 1'b1);

        // Reset asserted after 50 words have been transferred.
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 300; c++) begin
            if (out_valid && out_ready) begin
                check("pre_reset_data", 64'(out_data), 64'(32'hA500_0000 + n));
                n++;
            end
            if (n == 50) break;
            @(negedge clock);
        end
        check("pre_reset_words", 64'(n), 64'd50);
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        check("midrst_mem_address", 64'(mem_address), 64'd0);
        check("midrst_out_data", 64'(out_data), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_last", 64'(out_last), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        run_stream("after_reset", 0, 3, 130, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
